// File: rtl/param_piso.sv
// param_piso: parallel-in serial-out shifter with a one-word holding buffer,
// back-pressure stall, and gapless word-to-word handover.
module param_piso #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] IN,
    input  logic             STALL,
    output logic             READY,
    output logic             OUT,
    output logic             OUT_VALID,
    output logic             OUT_LAST,
    output logic             BUSY
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sr, hold;
    logic [CW-1:0] cnt;
    logic full, accept, last, done;
    assign READY     = !full;
    assign accept    = EN && READY;
    assign BUSY      = state == SHIFT;
    assign OUT_VALID = BUSY;
    assign last      = cnt == CW'(WIDTH - 1);
    assign OUT_LAST  = BUSY && last;
    assign OUT       = BUSY && (LSB_FIRST ? sr[0] : sr[WIDTH-1]);
    assign done      = BUSY && !STALL && last;
    always_ff @(posedge CLK)
        if (RST) state <= IDLE;
        else     state <= state_n;
    always_comb begin
        state_n = state;
        if (state == IDLE && accept) state_n = SHIFT;
        if (done && !full && !accept) state_n = IDLE;
    end
    // Completion reloads from the buffer first, else bypasses IN directly.
    always_ff @(posedge CLK)
        if (RST) begin
            cnt  <= '0;
            full <= 1'b0;
        end else begin
            if (state == IDLE) begin
                cnt <= '0;
                if (accept) sr <= IN;
            end else if (!STALL) begin
                if (last) begin
                    cnt <= '0;
                    if (full) sr <= hold;
                    else if (accept) sr <= IN;
                end else begin
                    cnt <= cnt + 1'b1;
                    sr  <= LSB_FIRST ? sr >> 1 : sr << 1;
                end
            end
            if (BUSY && accept && !done) begin
                hold <= IN;
                full <= 1'b1;
            end else if (done) full <= 1'b0;
        end
endmodule

// File: doc/param_piso.md
PARAM_PISO -- requirements
Module: param_piso

Interface
REQ-001 Parameter: WIDTH, default 16, parallel word width in bits; legal range 2..64.
REQ-002 Parameter: LSB_FIRST, default 0; 0 = serialise MSB first, 1 = serialise LSB first.
REQ-003 Port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: RST  input  1  reset, synchronous, active-high.
REQ-005 Port: EN  input  1  load request; IN is accepted on a rising edge where EN=1 and READY=1.
REQ-006 Port: IN  input  WIDTH  parallel data word.
REQ-007 Port: STALL  input  1  downstream back-pressure; 1 freezes serial output.
REQ-008 Port: READY  output  1  holding buffer empty; a word can be accepted.
REQ-009 Port: OUT  output  1  serial data bit, registered.
REQ-010 Port: OUT_VALID  output  1  OUT carries a valid bit.
REQ-011 Port: OUT_LAST  output  1  OUT carries the final bit of a word.
REQ-012 Port: BUSY  output  1  high in state SHIFT.

Function
REQ-013 Storage shall be a WIDTH-bit shift register, a WIDTH-bit one-entry holding buffer with a full flag, and a bit counter of ceil(log2(WIDTH)) bits.
REQ-014 The FSM shall have two states: IDLE and SHIFT.
REQ-015 READY shall equal NOT(holding-buffer full), combinationally from the registered flag.
REQ-016 IDLE + accept: load IN into the shift register, set counter 0, go to SHIFT; the first bit (IN[WIDTH-1], or IN[0] if LSB_FIRST) appears on OUT with OUT_VALID=1 in the next cycle.
REQ-017 In SHIFT with STALL=0: advance one bit per cycle; a word occupies exactly WIDTH consecutive OUT_VALID cycles.
REQ-018 In SHIFT with STALL=1: OUT, OUT_VALID, OUT_LAST and the counter shall hold; accepts into the holding buffer shall still occur.
REQ-019 OUT_LAST shall be 1 only during the cycle that presents bit WIDTH-1 of the word (counter = WIDTH-1).
REQ-020 SHIFT + accept, not completing: IN goes into the holding buffer and the buffer is marked full.
REQ-021 Completion (OUT_LAST=1, STALL=0) with buffer full: the buffer word is moved into the shift register, the buffer is cleared, and the FSM stays in SHIFT; the next word's first bit follows with no idle cycle.
REQ-022 Completion with buffer empty and EN=1 in the same cycle: IN bypasses directly into the shift register; no gap.
REQ-023 Completion with buffer empty and EN=0: go to IDLE; next cycle OUT=0, OUT_VALID=0, OUT_LAST=0, BUSY=0.
REQ-024 EN=1 while READY=0 shall be ignored; no state or data change occurs.
REQ-025 Changes of IN on non-accept cycles shall not affect data in flight.
REQ-026 In IDLE, OUT shall be driven 0.

Reset
REQ-027 RST=1 at a rising edge shall force IDLE, counter 0, holding buffer empty, OUT=0, OUT_VALID=0, OUT_LAST=0, BUSY=0, READY=1; this overrides EN and STALL.
REQ-028 Reset mid-word shall discard both the word in flight and the buffered word; the first post-reset cycle with OUT_VALID=1 shall carry the first bit of a newly accepted word.
REQ-029 Shift register and holding-buffer contents need no reset value; the outputs shall not depend on them while OUT_VALID=0.

Verification (WIDTH=16 unless stated)
REQ-030 Accept 16'hFFFF in IDLE, STALL=0 -> 16 cycles of OUT=1/OUT_VALID=1, OUT_LAST on the 16th, then IDLE with OUT=0.
REQ-031 Accept 16'hAFF5 with LSB_FIRST=0, then repeat with LSB_FIRST=1 -> serial 1010111111110101, then 1010111111110101 reversed (1010111111110101 is a palindrome; also check 16'h0FF5 -> 0000111111110101 and 1010111111110000).
REQ-032 Accept 16'hAFF5, then 16'h0FF5 while shifting (READY falls) -> 32 contiguous OUT_VALID cycles, two OUT_LAST pulses, READY back to 1 at the handover.
REQ-033 Third EN while the buffer is full -> ignored; the output stream is unchanged.
REQ-034 STALL=1 for 3 cycles mid-word -> OUT and OUT_VALID frozen, counter unchanged; the word completes in 16+3 cycles.
REQ-035 RST at bit 7 with a buffered word -> next cycle all outputs at reset values, READY=1; a fresh 16'h00FF serialises correctly afterwards.
